// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Define BCD_SATURATE_EN to clamp o_bcd to all nines on overflow instead of truncating.
module bin_to_bcd_seq #(
    parameter int W      = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [W-1:0]          i_binary,
    output logic                  o_busy,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_overflow,
    output logic                  o_dv
);

    localparam int IDIG = (W + 2) / 3;
    localparam int MAXD = (IDIG > DIGITS) ? IDIG : DIGITS;
    localparam int CW   = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [W-1:0]         shift_q, shift_d;
    logic [4*IDIG-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic                 dv_q;

    logic [4*IDIG-1:0]    adj;
    logic [4*MAXD-1:0]    ext;

    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < IDIG; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    shift_d   = i_binary;
                    scratch_d = '0;
                    cnt_d     = CNT_INIT;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scratch_d, shift_d} = {adj[4*IDIG-2:0], shift_q, 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Zero-extend scratch so DIGITS may be wider or narrower than IDIG.
    always_comb begin
        ext = '0;
        ext[4*IDIG-1:0] = scratch_q;
        ovf_d = 1'b0;
        for (int unsigned i = DIGITS; i < MAXD; i++)
            ovf_d = ovf_d | (|ext[4*i +: 4]);
`ifdef BCD_SATURATE_EN
        bcd_d = ovf_d ? {DIGITS{4'h9}} : ext[4*DIGITS-1:0];
`else
        bcd_d = ext[4*DIGITS-1:0];
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            dv_q      <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                bcd_q <= bcd_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_bcd      = bcd_q;
    assign o_overflow = ovf_q;
    assign o_dv       = dv_q;

endmodule
